// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register that holds control transfers for the PC stall
// and inserts one NOP bubble while the PC redirects.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IP,
    input  logic [31:0] PC_def,
    input  logic [31:0] imem_rdata,
    input  logic        b_taken,
    input  logic        id_stall,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [6:0]  OP,
    output logic [31:0] up_amt,
    output logic [11:0] immm
);
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;
    typedef enum logic [1:0] {RUN, HOLD, REDIRECT} state_t;
    state_t state, state_n;
    logic [31:0] instr_n, pc_n, pc4_n;
    logic valid_n, jump, ct;
    assign OP = id_instr[6:0];
    assign immm = id_instr[31:20];
    assign jump = OP == JAL || OP == JALR;
    assign ct = jump || OP == BR;
    assign up_amt = OP == JAL ? {{12{id_instr[31]}}, id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0} :
                    OP == BR  ? {{20{id_instr[31]}}, id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0} :
                    32'd0;
    always_comb begin
        state_n = state;
        instr_n = id_instr;
        pc_n = id_pc;
        pc4_n = id_pc4;
        valid_n = id_valid;
        if (!id_stall) begin
            if (state == RUN && ct && id_valid) begin
                state_n = HOLD;
            end else if (state == HOLD && (b_taken || jump)) begin
                // fall-through fetch is dropped; the bubble carries the PC's current IP
                instr_n = NOP_INSTR;
                valid_n = 1'b0;
                pc_n = IP;
                pc4_n = PC_def;
                state_n = REDIRECT;
            end else begin
                instr_n = imem_rdata;
                valid_n = 1'b1;
                pc_n = IP;
                pc4_n = PC_def;
                state_n = RUN;
            end
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= RUN;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
            id_pc <= RESET_PC;
            id_pc4 <= RESET_PC + 32'd4;
        end else begin
            state <= state_n;
            id_instr <= instr_n;
            id_valid <= valid_n;
            id_pc <= pc_n;
            id_pc4 <= pc4_n;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: randomized bench comparing if_id_stage against a hold-flag behavioural model,
// plus directed literal checks of reset, branches, jumps, stalls and reset during hold.
module tb_if_id_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] BEQ16 = 32'h0000_0863;
    localparam logic [31:0] JALM8 = 32'hFF9F_F06F;
    localparam logic [31:0] JALR7FC = 32'h7FC0_8067;
    logic clk = 0, rst = 1;
    logic [31:0] ip = 0, pc_def = 4, rdata = 0;
    logic b_taken = 0, id_stall = 0;
    logic [31:0] id_instr, id_pc, id_pc4, up_amt;
    logic id_valid;
    logic [6:0] op;
    logic [11:0] immm;
    int errors = 0, checks = 0;
    logic [31:0] m_instr, m_pc, m_pc4;
    logic m_valid, m_held;

    if_id_stage dut (
        .CLK(clk), .RESET(rst), .IP(ip), .PC_def(pc_def), .imem_rdata(rdata),
        .b_taken(b_taken), .id_stall(id_stall), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc4(id_pc4), .id_valid(id_valid), .OP(op), .up_amt(up_amt), .immm(immm)
    );

    always #5 clk = ~clk;

    function automatic logic is_ct(input logic [6:0] o);
        return o == 7'h6F || o == 7'h67 || o == 7'h63;
    endfunction

    // immediates from field weights rather than bit concatenation
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        v = 0;
        if (i[6:0] == 7'h63)
            v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048 - int'(i[31]) * 4096;
        else if (i[6:0] == 7'h6F)
            v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096 - int'(i[31]) * (1 << 20);
        return 32'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: a valid control transfer is held once, then jumps/taken branches become a bubble
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_instr <= NOP; m_pc <= 0; m_pc4 <= 4; m_valid <= 0; m_held <= 0;
        end else if (!id_stall) begin
            if (m_valid && is_ct(m_instr[6:0]) && !m_held) begin
                m_held <= 1;
            end else if (m_held && (b_taken || m_instr[6:0] != 7'h63)) begin
                m_instr <= NOP; m_valid <= 0; m_pc <= ip; m_pc4 <= pc_def; m_held <= 0;
            end else begin
                m_instr <= rdata; m_valid <= 1; m_pc <= ip; m_pc4 <= pc_def; m_held <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("instr", id_instr, m_instr);
        chk("pc", id_pc, m_pc);
        chk("pc4", id_pc4, m_pc4);
        chk("valid", 32'(id_valid), 32'(m_valid));
        chk("op", 32'(op), 32'(m_instr[6:0]));
        chk("up_amt", up_amt, ref_imm(m_instr));
        chk("immm", 32'(immm), 32'(m_instr[31:20]));
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] ins, input logic bt, input logic st);
        ip = a; pc_def = a + 4; rdata = ins; b_taken = bt; id_stall = st;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1;
        #1;
        chk("rst_instr", id_instr, NOP);
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_pc4", id_pc4, 4);
        #3 rst = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [6];
        ops = '{7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h03};
        return {$urandom()} & 32'hFFFF_FF80 | 32'(ops[$urandom_range(0, 5)]);
    endfunction

    initial begin
        logic [31:0] a;
        #3 rst = 0;
        drive(0, ADDI, 0, 0);
        chk("s0_pc", id_pc, 0);
        chk("s0_instr", id_instr, ADDI);
        chk("s0_valid", 32'(id_valid), 1);
        drive(4, ADDI, 0, 0);
        drive(8, ADDI, 0, 0);
        drive(12, ADDI, 0, 0);
        chk("s3_pc", id_pc, 12);
        chk("s3_pc4", id_pc4, 16);
        pulse_reset();
        drive(32'h10, BEQ16, 0, 0);
        chk("beq_up", up_amt, 16);
        drive(32'h14, ADDI, 0, 0);
        chk("beq_hold_pc", id_pc, 32'h10);
        drive(32'h14, ADDI, 1, 0);
        chk("bub_valid", 32'(id_valid), 0);
        chk("bub_op", 32'(op), 32'h13);
        drive(32'h20, ADDI, 0, 0);
        chk("tgt_pc", id_pc, 32'h20);
        drive(32'h10, BEQ16, 0, 0);
        drive(32'h14, ADDI, 0, 0);
        drive(32'h14, ADDI, 0, 0);
        chk("nt_pc", id_pc, 32'h14);
        chk("nt_valid", 32'(id_valid), 1);
        drive(32'h30, JALM8, 0, 0);
        chk("jal_up", up_amt, 32'hFFFF_FFF8);
        drive(32'h34, ADDI, 0, 0);
        drive(32'h34, ADDI, 0, 0);
        chk("jal_bub", 32'(id_valid), 0);
        drive(32'h28, ADDI, 0, 0);
        drive(32'h40, JALR7FC, 0, 0);
        chk("jalr_immm", 32'(immm), 32'h7FC);
        drive(32'h44, ADDI, 0, 0);
        repeat (3) drive(32'h44, ADDI, 1, 1);
        chk("stall_hold_pc", id_pc, 32'h40);
        chk("stall_hold_op", 32'(op), 32'h67);
        drive(32'h44, ADDI, 0, 0);
        chk("jalr_bub", 32'(id_valid), 0);
        repeat (3) drive(32'h50, ADDI, 0, 1);
        chk("stall_redir", 32'(id_valid), 0);
        drive(32'h50, ADDI, 0, 0);
        chk("redir_pc", id_pc, 32'h50);
        drive(32'h60, BEQ16, 0, 0);
        drive(32'h64, ADDI, 0, 0);
        pulse_reset();
        drive(32'h64, ADDI, 1, 0);
        chk("post_rst_pc", id_pc, 32'h64);
        chk("post_rst_valid", 32'(id_valid), 1);
        a = 32'h100;
        repeat (3000) begin
            a = ($urandom_range(0, 7) == 0) ? {$urandom()} & 32'hFFFF_FFFC : a + 4;
            drive(a, rand_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0);
            if ($urandom_range(0, 60) == 0) pulse_reset();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
